// File: rtl/qif_pkg.sv
// Shared types and helpers for the QIF neuron scheduler:
// value width, default potentials, saturation and FSM states.
package qif_pkg;

    localparam int V_W = 8;

    localparam logic signed [V_W-1:0] V_RESET_DEF = -8'sd20;
    localparam logic signed [V_W-1:0] V_PEAK_DEF  = 8'sd50;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        COMPUTE,
        WRITE,
        DONE
    } qif_state_t;

    // Clamp a 17-bit signed intermediate into the signed 8-bit range
    function automatic logic signed [V_W-1:0] sat8(
        input logic signed [16:0] x
    );
        if (x > 17'sd127) begin
            return 8'sd127;
        end else if (x < -17'sd128) begin
            return -8'sd128;
        end else begin
            return x[V_W-1:0];
        end
    endfunction

endpackage

// File: rtl/qif_update_core.sv
// Combinational QIF membrane update: V' = sat8(V + (V>>>3)^2 * (B>>>2)),
// or reset to V_RESET with a spike once V reaches V_PEAK.
// Ports: v_in, b_in (signed 8) -> v_out (signed 8), spike.
module qif_update_core
    import qif_pkg::*;
#(
    parameter logic signed [V_W-1:0] V_RESET = V_RESET_DEF,
    parameter logic signed [V_W-1:0] V_PEAK  = V_PEAK_DEF
) (
    input  logic signed [V_W-1:0] v_in,
    input  logic signed [V_W-1:0] b_in,
    output logic signed [V_W-1:0] v_out,
    output logic                  spike
);

    logic signed [16:0] v_ext;
    logic signed [16:0] b_ext;
    logic signed [16:0] v_q;
    logic signed [16:0] b_q;
    logic signed [16:0] acc;

    always_comb begin
        v_ext = {{9{v_in[V_W-1]}}, v_in};
        b_ext = {{9{b_in[V_W-1]}}, b_in};
        v_q   = v_ext >>> 3;
        b_q   = b_ext >>> 2;
        // |v_q|<=16, |b_q|<=32: the product stays within 17 bits
        acc   = v_ext + v_q * v_q * b_q;
        spike = (v_in >= V_PEAK);
        v_out = spike ? V_RESET : sat8(acc);
    end

endmodule

// File: rtl/qif_neuron_scheduler.sv
// Sweeps one shared QIF update core over NUM_NEURONS stored potentials per
// tick, emitting spikes through a valid/ready port that can stall the sweep.
// Ports: clk, rst_n (async, active-high), tick, cfg_we/cfg_addr/cfg_bias,
//   spike_valid/spike_ready/spike_id, v_mon, busy, sweep_done, overrun.
// Option: define QIF_REFRACTORY_EN for per-neuron refractory counters.
module qif_neuron_scheduler
    import qif_pkg::*;
#(
    parameter int                    NUM_NEURONS = 4,
    parameter logic signed [V_W-1:0] V_RESET     = V_RESET_DEF,
    parameter logic signed [V_W-1:0] V_PEAK      = V_PEAK_DEF,
    parameter int                    REFRACT     = 2,
    localparam int                   AW          = $clog2(NUM_NEURONS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic signed [V_W-1:0] cfg_bias,
    output logic                  spike_valid,
    input  logic                  spike_ready,
    output logic [AW-1:0]         spike_id,
    output logic signed [V_W-1:0] v_mon,
    output logic                  busy,
    output logic                  sweep_done,
    output logic                  overrun
);

    localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

    qif_state_t state;
    qif_state_t state_nx;

    logic [AW-1:0]         idx;
    logic signed [V_W-1:0] v_mem [NUM_NEURONS];
    logic signed [V_W-1:0] b_mem [NUM_NEURONS];
    logic signed [V_W-1:0] v_cur;
    logic signed [V_W-1:0] b_cur;
    logic signed [V_W-1:0] v_res;
    logic                  spk_res;
    logic signed [V_W-1:0] core_v;
    logic                  core_spk;
    logic                  wb;

`ifdef QIF_REFRACTORY_EN
    logic [1:0] refr [NUM_NEURONS];
    logic       hold_res;
`else
    logic unused_refract;
    assign unused_refract = ^REFRACT;
`endif

    qif_update_core #(
        .V_RESET (V_RESET),
        .V_PEAK  (V_PEAK)
    ) u_core (
        .v_in  (v_cur),
        .b_in  (b_cur),
        .v_out (core_v),
        .spike (core_spk)
    );

    // A spiking write-back waits for the downstream accept
    assign wb = (state == WRITE) && (!spk_res || spike_ready);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (tick) state_nx = FETCH;
            FETCH:   state_nx = COMPUTE;
            COMPUTE: state_nx = WRITE;
            WRITE:   if (wb) state_nx = (idx == LAST) ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        sweep_done  = (state == DONE);
        spike_valid = (state == WRITE) && spk_res;
        spike_id    = idx;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            idx     <= '0;
            v_cur   <= '0;
            b_cur   <= '0;
            v_res   <= '0;
            spk_res <= 1'b0;
            v_mon   <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_mem[i] <= V_RESET;
                b_mem[i] <= '0;
            end
`ifdef QIF_REFRACTORY_EN
            hold_res <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                refr[i] <= '0;
            end
`endif
        end else begin
            // Any tick outside IDLE (including DONE) is dropped
            overrun <= tick && (state != IDLE);
            if (cfg_we) begin
                b_mem[cfg_addr] <= cfg_bias;
            end
            if (state == FETCH) begin
                v_cur <= v_mem[idx];
                b_cur <= b_mem[idx];
            end
            if (state == COMPUTE) begin
`ifdef QIF_REFRACTORY_EN
                if (refr[idx] != 2'd0) begin
                    v_res    <= V_RESET;
                    spk_res  <= 1'b0;
                    hold_res <= 1'b1;
                end else begin
                    v_res    <= core_v;
                    spk_res  <= core_spk;
                    hold_res <= 1'b0;
                end
`else
                v_res   <= core_v;
                spk_res <= core_spk;
`endif
            end
            if (wb) begin
                v_mem[idx] <= v_res;
                v_mon      <= v_res;
                idx        <= (idx == LAST) ? '0 : idx + 1'b1;
`ifdef QIF_REFRACTORY_EN
                if (hold_res) begin
                    refr[idx] <= refr[idx] - 2'd1;
                end else if (spk_res) begin
                    refr[idx] <= 2'(REFRACT);
                end
`endif
            end
        end
    end

endmodule
